// File: rtl/constants.sv
// constants: widths shared between the CPU and its boot-time loader.
`default_nettype none
package constants;
  localparam int WORD_SIZE  = 19;
  localparam int ADDR_WIDTH = 12;
endpackage
`default_nettype wire

// File: rtl/loader_pkg.sv
// loader_pkg: program loader state encoding and frame field widths.
`default_nettype none
package loader_pkg;
  import constants::*;

  localparam int BYTES_PER_WORD = 3;
  localparam int BYTE_W         = 8;
  localparam int LEN_W          = 12;
  localparam int HI_BITS        = WORD_SIZE - 2 * BYTE_W;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_LO = 4'd1,
    LEN_HI = 4'd2,
    B0     = 4'd3,
    B1     = 4'd4,
    B2     = 4'd5,
    WRITE  = 4'd6,
    CHECK  = 4'd7,
    RUN    = 4'd8,
    ERROR  = 4'd9
  } loader_state_t;
endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, instruction memory write port out.
`default_nettype none
interface program_loader_if;
  import constants::*;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [WORD_SIZE-1:0]  im_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface
`default_nettype wire

// File: rtl/word_packer.sv
// word_packer: collects byte0/byte1 and forms the word with the live byte2.
`default_nettype none
module word_packer
  import constants::*;
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_i,
  input  logic [7:0]           byte_i,
  output logic [WORD_SIZE-1:0] word_o,
  output logic                 pad_err_o
);
  logic [7:0] b0_q, b1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q <= '0;
      b1_q <= '0;
    end else if (shift_i) begin
      b0_q <= b1_q;
      b1_q <= byte_i;
    end
  end

  // byte2 is taken straight from the stream so the word is ready on its accept
  assign word_o    = {byte_i[HI_BITS-1:0], b1_q, b0_q};
  assign pad_err_o = |byte_i[7:HI_BITS];
endmodule
`default_nettype wire

// File: rtl/program_loader.sv
// program_loader: frame parser that fills instruction memory and starts the CPU.
`default_nettype none
module program_loader
  import constants::*;
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  program_loader_if.slave  bus,
  output logic             cpu_en_o,
  output logic             done_o,
  output logic             err_o
);
  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      left_q, left_d;
  logic [7:0]            chk_q, chk_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  we_q, rdy_q, run_q, err_q;
  logic                  accept, pad_err;
  logic [WORD_SIZE-1:0]  word;
  logic [LEN_W-1:0]      n_words;

  assign accept  = bus.in_valid & rdy_q;
  assign n_words = {bus.in_data[3:0], len_lo_q};

  word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_i   (accept && (state_q == B0 || state_q == B1)),
    .byte_i    (bus.in_data),
    .word_o    (word),
    .pad_err_o (pad_err)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    chk_d    = chk_q;
    len_lo_d = len_lo_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (start_i) begin
          state_d = LEN_LO;
          addr_d  = '0;
          chk_d   = '0;
        end
      end
      LEN_LO: if (accept) begin
        len_lo_d = bus.in_data;
        chk_d    = chk_q ^ bus.in_data;
        state_d  = LEN_HI;
      end
      LEN_HI: if (accept) begin
        chk_d = chk_q ^ bus.in_data;
        if (bus.in_data[7:4] != 4'd0) begin
          state_d = ERROR;
        end else if (n_words == '0) begin
          state_d = CHECK;
        end else begin
          left_d  = n_words;
          state_d = B0;
        end
      end
      B0: if (accept) begin
        chk_d   = chk_q ^ bus.in_data;
        state_d = B1;
      end
      B1: if (accept) begin
        chk_d   = chk_q ^ bus.in_data;
        state_d = B2;
      end
      B2: if (accept) begin
        if (pad_err) begin
          state_d = ERROR;
        end else begin
          chk_d   = chk_q ^ bus.in_data;
          wdata_d = word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        left_d  = left_q - 1'b1;
        state_d = (left_q == LEN_W'(1)) ? CHECK : B0;
      end
      CHECK: if (accept) begin
        state_d = (chk_q == bus.in_data) ? RUN : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      chk_q    <= '0;
      len_lo_q <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdy_q    <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      chk_q    <= chk_d;
      len_lo_q <= len_lo_d;
      wdata_q  <= wdata_d;
      we_q     <= (state_d == WRITE);
      rdy_q    <= (state_d inside {LEN_LO, LEN_HI, B0, B1, B2, CHECK});
      run_q    <= (state_d == RUN);
      err_q    <= (state_d == ERROR);
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.im_we    = we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign cpu_en_o     = run_q;
  assign done_o       = run_q;
  assign err_o        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames with a write scoreboard for program_loader.
`default_nettype none
module tb_program_loader;
  import constants::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_en, done, err;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   spurious = 0;
  int   timeouts = 0;
  int   t_start = 0;
  logic [30:0] exp_q[$];
  logic [18:0] words[8];

  program_loader_if bus();

  program_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .bus      (bus),
    .cpu_en_o (cpu_en),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected (addr, data) pair
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        logic [30:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.im_addr), 32'(e[30:19]));
        check("wr_data", 32'(bus.im_wdata), 32'(e[18:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeouts++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  task automatic send_frame(input int n, input logic [7:0] flip, input int maxgap);
    logic [7:0] x, b;
    x = 8'(n);
    send_byte(8'(n), pick_gap(maxgap));
    b = {4'd0, 4'(n >> 8)};
    x ^= b;
    send_byte(b, pick_gap(maxgap));
    for (int i = 0; i < n; i++) begin
      b = words[i][7:0];   x ^= b; send_byte(b, pick_gap(maxgap));
      b = words[i][15:8];  x ^= b; send_byte(b, pick_gap(maxgap));
      b = {5'd0, words[i][18:16]}; x ^= b;
      exp_q.push_back({12'(i), words[i]});
      send_byte(b, pick_gap(maxgap));
    end
    send_byte(x ^ flip, pick_gap(maxgap));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    t_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_of_test(input string tag);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_spurious"}, 32'(spurious), 32'd0);
    check({tag, "_timeouts"}, 32'(timeouts), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_im_we", 32'(bus.im_we), 32'd0);
    check("rst_im_addr", 32'(bus.im_addr), 32'd0);
    check("rst_im_wdata", 32'(bus.im_wdata), 32'd0);
    check("rst_outs", 32'({cpu_en, done, err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=2, back-to-back timing
    words[0] = 19'h12345; words[1] = 19'h7FFFF;
    pulse_start();
    send_frame(2, 8'h00, 0);
    check("t1_latency", 32'(cyc - t_start), 32'd11);
    check("t1_run", 32'({cpu_en, done, err}), 32'b110);
    end_of_test("t1");

    // N=0 from RUN
    pulse_start();
    check("t2_cleared", 32'({cpu_en, done, err}), 32'd0);
    send_frame(0, 8'h00, 0);
    check("t2_run", 32'({cpu_en, done, err}), 32'b110);
    end_of_test("t2");

    // bad checksum, then good reload
    words[0] = 19'h00ABC;
    pulse_start();
    send_frame(1, 8'h01, 0);
    check("t3_err", 32'({cpu_en, done, err}), 32'b001);
    words[0] = 19'h5A5A5; words[1] = 19'h00001;
    pulse_start();
    check("t3_err_cleared", 32'(err), 32'd0);
    send_frame(2, 8'h00, 0);
    check("t3_reload", 32'({cpu_en, done, err}), 32'b110);
    end_of_test("t3");

    // pad bits set in byte2
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h08, 0);
    check("t4_pad_err", 32'({cpu_en, done, err}), 32'b001);
    check("t4_pad_ready", 32'(bus.in_ready), 32'd0);
    repeat (4) @(negedge clk);
    end_of_test("t4");

    // bad LEN_HI
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h10, 0);
    check("t4_lenhi_err", 32'({cpu_en, done, err}), 32'b001);
    check("t4_lenhi_ready", 32'(bus.in_ready), 32'd0);
    end_of_test("t4b");

    // N=3 gap-free, then with random gaps: same writes expected
    words[0] = 19'h3C3C3; words[1] = 19'h40000; words[2] = 19'h0FF00;
    pulse_start();
    send_frame(3, 8'h00, 0);
    check("t5_nogap_run", 32'({cpu_en, done, err}), 32'b110);
    pulse_start();
    send_frame(3, 8'h00, 5);
    check("t5_gap_run", 32'({cpu_en, done, err}), 32'b110);
    end_of_test("t5");

    // reset between byte1 and byte2 of the second word
    words[0] = 19'h11111; words[1] = 19'h22222;
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(words[0][7:0], 0); send_byte(words[0][15:8], 0);
    exp_q.push_back({12'd0, words[0]});
    send_byte({5'd0, words[0][18:16]}, 0);
    send_byte(words[1][7:0], 0); send_byte(words[1][15:8], 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
    check("t6_rst_we", 32'(bus.im_we), 32'd0);
    check("t6_rst_addr", 32'(bus.im_addr), 32'd0);
    check("t6_rst_wdata", 32'(bus.im_wdata), 32'd0);
    check("t6_rst_outs", 32'({cpu_en, done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    end_of_test("t6_hold");
    words[0] = 19'h6789A; words[1] = 19'h00F0F;
    pulse_start();
    send_frame(2, 8'h00, 0);
    check("t6_reload", 32'({cpu_en, done, err}), 32'b110);
    end_of_test("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time upstream stage of the 19-bit CPU. It receives a framed byte stream over a valid/ready handshake and packs three bytes into each 19-bit instruction word. It writes the words sequentially into instruction memory through the memory write port (write enable, address, write data), verifies an XOR checksum, and on success raises the CPU enable so execution starts at address 0.

## Interface
- WORD_SIZE, 19, instruction word width (from shared `constants`)
- ADDR_WIDTH, 12, instruction memory address width
- BYTES_PER_WORD, 3, stream bytes per instruction word
- CLK  input  1  rising-edge clock, single domain
- RST_N  input  1  asynchronous active-low reset
- START  input  1  one-cycle pulse; begins a load (sampled in IDLE, RUN, ERROR)
- IN_DATA  input  8  stream byte
- IN_VALID  input  1  IN_DATA valid
- IN_READY  output  1  loader can accept a byte this cycle
- IM_WE  output  1  instruction memory write enable, drives the CPU's IM write-enable
- IM_ADDR  output  ADDR_WIDTH  write address
- IM_WDATA  output  WORD_SIZE  write data, drives the CPU's code input
- CPU_EN  output  1  CPU run enable
- DONE  output  1  load completed, checksum good
- ERR  output  1  load failed (format or checksum)

## Operation
- Frame format: LEN_LO, LEN_HI, then N words of 3 bytes each, little-endian (byte0 = bits 7:0, byte1 = bits 15:8, byte2 bits 2:0 = bits 18:16), then a CHK byte.
- N = {LEN_HI[3:0], LEN_LO}, range 0..4095. LEN_HI[7:4] != 0 -> ERROR.
- byte2[7:3] != 0 -> ERROR, and the word is not written.
- A byte is accepted when IN_VALID && IN_READY. IN_DATA is ignored otherwise.
- Checksum: running XOR of every accepted byte from LEN_LO through the last data byte. It is cleared on START. The load passes when the accumulated XOR equals CHK.
- States and transitions:
  - IDLE → LEN_LO on START.
  - LEN_LO → LEN_HI.
  - LEN_HI → CHECK if N = 0, else → B0.
  - B0 → B1 → B2.
  - B2 → WRITE.
  - WRITE → B0 if words remaining, else → CHECK.
  - CHECK → RUN on match, else → ERROR.
  - RUN / ERROR → LEN_LO on START (reload). This clears DONE, ERR and CPU_EN, and resets the address pointer to 0.
- IN_READY = 1 only in LEN_LO, LEN_HI, B0, B1, B2 and CHECK.
- START is ignored in every state other than IDLE, RUN and ERROR.
- Address pointer starts at 0 on each load and increments after each write. The last write is at N-1, so the pointer never wraps.
- CPU_EN = DONE = 1 only in RUN. ERR = 1 only in ERROR.

## Timing
- Reset values: IN_READY = 0, IM_WE = 0, IM_ADDR = 0, IM_WDATA = 0, CPU_EN = 0, DONE = 0, ERR = 0. State is IDLE.
- Reset is asynchronous. Asserting it mid-load returns to IDLE immediately, and no further IM_WE is issued.
- Registered outputs only. IM_WE is high for exactly one cycle, the WRITE state, which is the cycle after byte2 is accepted. IM_ADDR and IM_WDATA are stable during that cycle. IN_READY = 0 during WRITE.
- Back-to-back stream rate: 4 cycles per word (3 accept cycles + WRITE). Minimum load time is 3 + 4N cycles from START to RUN entry.
- CPU_EN rises the cycle after the CHK byte is accepted, and stays high until reset or START.
- Error detection (bad LEN_HI or bad byte2) enters ERROR on the next cycle. Remaining stream bytes are not accepted.
- START arriving in the same cycle as a byte accept in CHECK is ignored.

## Structure
- Shared package `constants`: WORD_SIZE, ADDR_WIDTH.
- New package `loader_pkg`: state enum `loader_state_t` (IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, CHECK, RUN, ERROR), BYTES_PER_WORD, and frame field widths.
- One sub-module, `word_packer`: byte-lane shift into the 19-bit word, plus pad-bit check flag. The FSM, counters and XOR accumulator live in `program_loader`.

## Test plan
- N = 2, words 0x12345 and 0x7FFFF, correct CHK, IN_VALID held high → two writes: 0x12345 at address 0, then 0x7FFFF at address 1. CPU_EN = DONE = 1 exactly 11 cycles after START.
- N = 0, stream 0x00, 0x00, CHK = 0x00 → no IM_WE, RUN reached, CPU_EN = 1.
- N = 1 with CHK off by 0x01 → one write occurs, then ERROR: ERR = 1, CPU_EN = 0. A following START with a good frame ends in RUN with ERR = 0.
- byte2 = 0x08 in the first word → no IM_WE, ERR = 1. LEN_HI = 0x10 → ERR = 1 after the header.
- Random IN_VALID gaps of 0–5 cycles, N = 3 → same written words and addresses as the gap-free run, and no byte accepted while IN_READY = 0.
- RST_N asserted between byte1 and byte2 of the second word → all outputs 0 immediately, no further writes. A new START plus a full frame loads correctly from address 0.
